// File: rtl/pc_sequencer.sv
// Program-counter and control-flow sequencer for the 16-bit execute stage.
// Resolves jumps, returns and halt, and owns a small circular return-address stack.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          STACK_DEPTH = 4,
  parameter int          SP_W        = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [5:0]      op_dec,
  input  logic [15:0]     imm,
  input  logic [15:0]     ex_pc,
  input  logic [1:0]      flag_ex,
  input  logic            stall_in,
  input  logic            resume,
  output logic [15:0]     pc,
  output logic            flush,
  output logic            taken,
  output logic            halted,
  output logic [SP_W:0]   stack_cnt,
  output logic            stack_err
);

  localparam logic [5:0] OP_JMP = 6'b011000;
  localparam logic [5:0] OP_JV  = 6'b011100;
  localparam logic [5:0] OP_JNV = 6'b011101;
  localparam logic [5:0] OP_JZ  = 6'b011110;
  localparam logic [5:0] OP_JNZ = 6'b011111;
  localparam logic [5:0] OP_RET = 6'b010000;
  localparam logic [5:0] OP_HLT = 6'b010001;

  localparam logic [SP_W-1:0] SP_ONE   = SP_W'(1);
  localparam logic [SP_W:0]   CNT_ONE  = (SP_W+1)'(1);
  localparam logic [SP_W:0]   CNT_FULL = (SP_W+1)'(STACK_DEPTH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            taken_q, taken_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [SP_W-1:0] topIdx;
  logic [SP_W:0]   cnt_q, cnt_d;
  logic [15:0]     stackMem_q [STACK_DEPTH];
  logic            push;
  logic            redirect;
  logic [15:0]     target;

  // A full stack keeps writing at sp, which on a circular buffer is the oldest entry.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush_d  = 1'b0;
    taken_d  = 1'b0;
    halted_d = halted_q;
    err_d    = err_q;
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    redirect = 1'b0;
    target   = imm;
    topIdx   = sp_q - SP_ONE;
    if (!stall_in) begin
      case (state_q)
        ST_RUN: begin
          pc_d = pc_q + 16'd1;
          case (op_dec)
            OP_JMP: begin
              push     = 1'b1;
              redirect = 1'b1;
            end
            OP_JV:  redirect = flag_ex[0];
            OP_JNV: redirect = !flag_ex[0];
            OP_JZ:  redirect = flag_ex[1];
            OP_JNZ: redirect = !flag_ex[1];
            OP_RET: begin
              redirect = 1'b1;
              if (cnt_q == '0) begin
                target = RESET_PC;
                err_d  = 1'b1;
              end else begin
                target = stackMem_q[topIdx];
                sp_d   = topIdx;
                cnt_d  = cnt_q - CNT_ONE;
              end
            end
            OP_HLT: begin
              pc_d     = pc_q;
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end
            default: ;
          endcase
          if (push) begin
            sp_d = sp_q + SP_ONE;
            if (cnt_q == CNT_FULL) begin
              err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          if (redirect) begin
            pc_d    = target;
            state_d = ST_FLUSH;
            flush_d = 1'b1;
            taken_d = 1'b1;
          end
        end
        ST_FLUSH: begin
          pc_d    = pc_q + 16'd1;
          state_d = ST_RUN;
        end
        ST_HALT: begin
          if (resume) begin
            state_d  = ST_RUN;
            halted_d = 1'b0;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      flush_q  <= 1'b0;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      sp_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      flush_q  <= flush_d;
      taken_q  <= taken_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      sp_q     <= sp_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset: entries are only read while cnt_q says they are valid.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      stackMem_q[sp_q] <= ex_pc + 16'd1;
    end
  end

  assign pc        = pc_q;
  assign flush     = flush_q;
  assign taken     = taken_q;
  assign halted    = halted_q;
  assign stack_cnt = cnt_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with fixed expectations,
// then randomized traffic compared against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_JMP = 6'b011000;
  localparam logic [5:0] OP_JV  = 6'b011100;
  localparam logic [5:0] OP_JNV = 6'b011101;
  localparam logic [5:0] OP_JZ  = 6'b011110;
  localparam logic [5:0] OP_JNZ = 6'b011111;
  localparam logic [5:0] OP_RET = 6'b010000;
  localparam logic [5:0] OP_HLT = 6'b010001;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  op_dec = '0;
  logic [15:0] imm = '0;
  logic [15:0] ex_pc = '0;
  logic [1:0]  flag_ex = '0;
  logic        stall_in = 1'b0;
  logic        resume = 1'b0;
  logic [15:0] pc;
  logic        flush;
  logic        taken;
  logic        halted;
  logic [2:0]  stack_cnt;
  logic        stack_err;

  int assertCount = 0;
  int failCount = 0;

  // Reference model: architectural view only (pending bubble, halted, LIFO queue).
  logic [15:0] mPc = '0;
  logic        mFlush = 1'b0;
  logic        mTaken = 1'b0;
  logic        mHalted = 1'b0;
  logic        mBubble = 1'b0;
  logic        mErr = 1'b0;
  logic [15:0] mStack [$];

  pc_sequencer #(
    .RESET_PC(16'h0000),
    .STACK_DEPTH(4),
    .SP_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .op_dec(op_dec),
    .imm(imm),
    .ex_pc(ex_pc),
    .flag_ex(flag_ex),
    .stall_in(stall_in),
    .resume(resume),
    .pc(pc),
    .flush(flush),
    .taken(taken),
    .halted(halted),
    .stack_cnt(stack_cnt),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  function automatic void modelEdge();
    logic        jump;
    logic [15:0] dest;
    mFlush = 1'b0;
    mTaken = 1'b0;
    if (reset === 1'b0) begin
      mPc = 16'h0000;
      mHalted = 1'b0;
      mBubble = 1'b0;
      mErr = 1'b0;
      mStack.delete();
    end else if (stall_in) begin
    end else if (mBubble) begin
      mBubble = 1'b0;
      mPc = mPc + 16'd1;
    end else if (mHalted) begin
      if (resume) mHalted = 1'b0;
    end else begin
      jump = 1'b0;
      dest = imm;
      case (op_dec)
        OP_JMP: begin
          mStack.push_back(ex_pc + 16'd1);
          if (mStack.size() > DEPTH) begin
            void'(mStack.pop_front());
            mErr = 1'b1;
          end
          jump = 1'b1;
        end
        OP_JV:  jump = (flag_ex[0] == 1'b1);
        OP_JNV: jump = (flag_ex[0] == 1'b0);
        OP_JZ:  jump = (flag_ex[1] == 1'b1);
        OP_JNZ: jump = (flag_ex[1] == 1'b0);
        OP_RET: begin
          jump = 1'b1;
          if (mStack.size() == 0) begin
            dest = 16'h0000;
            mErr = 1'b1;
          end else begin
            dest = mStack.pop_back();
          end
        end
        OP_HLT: mHalted = 1'b1;
        default: ;
      endcase
      if (jump) begin
        mPc = dest;
        mBubble = 1'b1;
        mFlush = 1'b1;
        mTaken = 1'b1;
      end else if (!mHalted) begin
        mPc = mPc + 16'd1;
      end
    end
  endfunction

  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic [15:0] im,
                               input logic [15:0] ep, input logic [1:0] fl, input logic st,
                               input logic rs);
    reset = r;
    op_dec = op;
    imm = im;
    ex_pc = ep;
    flag_ex = fl;
    stall_in = st;
    resume = rs;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic test_reset;
    applyStimulus(1'b0, OP_JMP, 16'h1234, 16'h0005, 2'b11, 1'b1, 1'b1);
    assertCount++; if (pc !== 16'h0000) begin failCount++; $display("[TB] FAIL reset_pc: got %h want %h", pc, 16'h0000); end
    assertCount++; if (flush !== 1'b0) begin failCount++; $display("[TB] FAIL reset_flush: got %b want 0", flush); end
    assertCount++; if (taken !== 1'b0) begin failCount++; $display("[TB] FAIL reset_taken: got %b want 0", taken); end
    assertCount++; if (halted !== 1'b0) begin failCount++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
    assertCount++; if (stack_cnt !== 3'd0) begin failCount++; $display("[TB] FAIL reset_cnt: got %0d want 0", stack_cnt); end
    assertCount++; if (stack_err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err: got %b want 0", stack_err); end
  endtask

  task automatic test_sequential;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, OP_NOP, 16'h0040, 16'h0000, 2'b00, 1'b0, 1'b0);
      assertCount++; if (pc !== 16'(i)) begin failCount++; $display("[TB] FAIL seq_pc: got %h want %h", pc, 16'(i)); end
      assertCount++; if (flush !== 1'b0) begin failCount++; $display("[TB] FAIL seq_flush: got %b want 0", flush); end
    end
  endtask

  task automatic test_branch;
    applyStimulus(1'b1, OP_JZ, 16'h0040, 16'h0004, 2'b10, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0040) begin failCount++; $display("[TB] FAIL jz_pc: got %h want %h", pc, 16'h0040); end
    assertCount++; if (flush !== 1'b1) begin failCount++; $display("[TB] FAIL jz_flush: got %b want 1", flush); end
    assertCount++; if (taken !== 1'b1) begin failCount++; $display("[TB] FAIL jz_taken: got %b want 1", taken); end
    applyStimulus(1'b1, OP_JMP, 16'h1234, 16'h0005, 2'b10, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0041) begin failCount++; $display("[TB] FAIL bubble_pc: got %h want %h", pc, 16'h0041); end
    assertCount++; if (flush !== 1'b0) begin failCount++; $display("[TB] FAIL bubble_flush: got %b want 0", flush); end
    assertCount++; if (taken !== 1'b0) begin failCount++; $display("[TB] FAIL bubble_taken: got %b want 0", taken); end
    assertCount++; if (stack_cnt !== 3'd0) begin failCount++; $display("[TB] FAIL bubble_cnt: got %0d want 0", stack_cnt); end
    applyStimulus(1'b1, OP_JNZ, 16'h0777, 16'h0041, 2'b10, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0042) begin failCount++; $display("[TB] FAIL jnz_pc: got %h want %h", pc, 16'h0042); end
    assertCount++; if (taken !== 1'b0) begin failCount++; $display("[TB] FAIL jnz_taken: got %b want 0", taken); end
    applyStimulus(1'b1, OP_JV, 16'h0080, 16'h0042, 2'b01, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0080) begin failCount++; $display("[TB] FAIL jv_pc: got %h want %h", pc, 16'h0080); end
    assertCount++; if (taken !== 1'b1) begin failCount++; $display("[TB] FAIL jv_taken: got %b want 1", taken); end
    applyStimulus(1'b1, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_JNV, 16'h0999, 16'h0081, 2'b01, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0082) begin failCount++; $display("[TB] FAIL jnv_pc: got %h want %h", pc, 16'h0082); end
  endtask

  task automatic test_wrap;
    applyStimulus(1'b0, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_JMP, 16'hFFFE, 16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'hFFFF) begin failCount++; $display("[TB] FAIL wrap_pre: got %h want %h", pc, 16'hFFFF); end
    applyStimulus(1'b1, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0000) begin failCount++; $display("[TB] FAIL wrap_pc: got %h want %h", pc, 16'h0000); end
  endtask

  task automatic test_call_return;
    applyStimulus(1'b0, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_JMP, 16'h0100, 16'h0010, 2'b00, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0100) begin failCount++; $display("[TB] FAIL call_pc: got %h want %h", pc, 16'h0100); end
    assertCount++; if (stack_cnt !== 3'd1) begin failCount++; $display("[TB] FAIL call_cnt: got %0d want 1", stack_cnt); end
    applyStimulus(1'b1, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_RET, 16'h0555, 16'h0101, 2'b00, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0011) begin failCount++; $display("[TB] FAIL ret_pc: got %h want %h", pc, 16'h0011); end
    assertCount++; if (stack_cnt !== 3'd0) begin failCount++; $display("[TB] FAIL ret_cnt: got %0d want 0", stack_cnt); end
    assertCount++; if (stack_err !== 1'b0) begin failCount++; $display("[TB] FAIL ret_err: got %b want 0", stack_err); end
    assertCount++; if (taken !== 1'b1) begin failCount++; $display("[TB] FAIL ret_taken: got %b want 1", taken); end
  endtask

  task automatic test_stack_overflow;
    logic [15:0] want;
    applyStimulus(1'b0, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, OP_JMP, 16'h1000 + 16'(i), 16'h0200 + 16'(16 * i), 2'b00, 1'b0, 1'b0);
      want = (i < 4) ? 16'(i + 1) : 16'd4;
      assertCount++; if (stack_cnt !== want[2:0]) begin failCount++; $display("[TB] FAIL push_cnt: got %0d want %0d", stack_cnt, want[2:0]); end
      assertCount++; if (stack_err !== (i == 4)) begin failCount++; $display("[TB] FAIL push_err: got %b want %b", stack_err, (i == 4)); end
      applyStimulus(1'b1, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, OP_RET, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
      want = 16'h0200 + 16'(16 * (4 - k)) + 16'd1;
      assertCount++; if (pc !== want) begin failCount++; $display("[TB] FAIL pop_pc: got %h want %h", pc, want); end
      applyStimulus(1'b1, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, OP_RET, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0000) begin failCount++; $display("[TB] FAIL underflow_pc: got %h want %h", pc, 16'h0000); end
    assertCount++; if (stack_cnt !== 3'd0) begin failCount++; $display("[TB] FAIL underflow_cnt: got %0d want 0", stack_cnt); end
    assertCount++; if (stack_err !== 1'b1) begin failCount++; $display("[TB] FAIL underflow_err: got %b want 1", stack_err); end
  endtask

  task automatic test_halt;
    applyStimulus(1'b0, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_JMP, 16'h001F, 16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_HLT, 16'h0000, 16'h0020, 2'b00, 1'b0, 1'b0);
    assertCount++; if (halted !== 1'b1) begin failCount++; $display("[TB] FAIL hlt_halted: got %b want 1", halted); end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, (i % 2 == 0) ? OP_JMP : OP_RET, 16'h0700, 16'h0020, 2'b11, 1'b0, 1'b0);
      assertCount++; if (pc !== 16'h0020) begin failCount++; $display("[TB] FAIL hlt_pc: got %h want %h", pc, 16'h0020); end
      assertCount++; if (taken !== 1'b0) begin failCount++; $display("[TB] FAIL hlt_taken: got %b want 0", taken); end
    end
    applyStimulus(1'b1, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b1, 1'b1);
    assertCount++; if (halted !== 1'b1) begin failCount++; $display("[TB] FAIL stall_resume: got %b want 1", halted); end
    applyStimulus(1'b1, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    assertCount++; if (halted !== 1'b1) begin failCount++; $display("[TB] FAIL resume_lost: got %b want 1", halted); end
    applyStimulus(1'b1, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1);
    assertCount++; if (halted !== 1'b0) begin failCount++; $display("[TB] FAIL resume_halted: got %b want 0", halted); end
    assertCount++; if (pc !== 16'h0020) begin failCount++; $display("[TB] FAIL resume_pc: got %h want %h", pc, 16'h0020); end
    applyStimulus(1'b1, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0021) begin failCount++; $display("[TB] FAIL after_resume_pc: got %h want %h", pc, 16'h0021); end
  endtask

  task automatic test_stall;
    applyStimulus(1'b0, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_JMP, 16'h0300, 16'h0001, 2'b00, 1'b1, 1'b0);
    assertCount++; if (pc !== 16'h0001) begin failCount++; $display("[TB] FAIL stall_pc: got %h want %h", pc, 16'h0001); end
    assertCount++; if (stack_cnt !== 3'd0) begin failCount++; $display("[TB] FAIL stall_cnt: got %0d want 0", stack_cnt); end
    applyStimulus(1'b1, OP_JMP, 16'h0300, 16'h0001, 2'b00, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0300) begin failCount++; $display("[TB] FAIL unstall_pc: got %h want %h", pc, 16'h0300); end
    applyStimulus(1'b1, OP_JMP, 16'h0500, 16'h0300, 2'b00, 1'b1, 1'b0);
    assertCount++; if (flush !== 1'b0) begin failCount++; $display("[TB] FAIL stall_flush: got %b want 0", flush); end
    assertCount++; if (pc !== 16'h0300) begin failCount++; $display("[TB] FAIL stall_flush_pc: got %h want %h", pc, 16'h0300); end
    applyStimulus(1'b1, OP_JMP, 16'h0500, 16'h0300, 2'b00, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0301) begin failCount++; $display("[TB] FAIL held_bubble_pc: got %h want %h", pc, 16'h0301); end
    assertCount++; if (stack_cnt !== 3'd1) begin failCount++; $display("[TB] FAIL held_bubble_cnt: got %0d want 1", stack_cnt); end
  endtask

  task automatic test_reset_in_flush;
    applyStimulus(1'b0, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b1, OP_JMP, 16'h0400, 16'h0050, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, OP_JMP, 16'h0400, 16'h0050, 2'b00, 1'b1, 1'b1);
    assertCount++; if (pc !== 16'h0000) begin failCount++; $display("[TB] FAIL rstflush_pc: got %h want %h", pc, 16'h0000); end
    assertCount++; if (flush !== 1'b0) begin failCount++; $display("[TB] FAIL rstflush_flush: got %b want 0", flush); end
    assertCount++; if (stack_cnt !== 3'd0) begin failCount++; $display("[TB] FAIL rstflush_cnt: got %0d want 0", stack_cnt); end
    assertCount++; if (stack_err !== 1'b0) begin failCount++; $display("[TB] FAIL rstflush_err: got %b want 0", stack_err); end
    applyStimulus(1'b1, OP_JMP, 16'h0600, 16'h0000, 2'b00, 1'b0, 1'b0);
    assertCount++; if (pc !== 16'h0600) begin failCount++; $display("[TB] FAIL rstflush_run: got %h want %h", pc, 16'h0600); end
  endtask

  task automatic test_random;
    logic [5:0] op;
    logic       r;
    logic       st;
    logic       rs;
    applyStimulus(1'b0, OP_NOP, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: op = OP_JMP;
        1: op = OP_JV;
        2: op = OP_JNV;
        3: op = OP_JZ;
        4: op = OP_JNZ;
        5: op = OP_RET;
        6: op = OP_HLT;
        default: op = 6'($urandom);
      endcase
      r = ($urandom_range(0, 63) != 0);
      st = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 3) == 0);
      applyStimulus(r, op, 16'($urandom), 16'($urandom), 2'($urandom), st, rs);
      assertCount++; if (pc !== mPc) begin failCount++; $display("[TB] FAIL rand_pc: got %h want %h", pc, mPc); end
      assertCount++; if (flush !== mFlush) begin failCount++; $display("[TB] FAIL rand_flush: got %b want %b", flush, mFlush); end
      assertCount++; if (taken !== mTaken) begin failCount++; $display("[TB] FAIL rand_taken: got %b want %b", taken, mTaken); end
      assertCount++; if (halted !== mHalted) begin failCount++; $display("[TB] FAIL rand_halted: got %b want %b", halted, mHalted); end
      assertCount++; if (stack_cnt !== 3'(mStack.size())) begin failCount++; $display("[TB] FAIL rand_cnt: got %0d want %0d", stack_cnt, mStack.size()); end
      assertCount++; if (stack_err !== mErr) begin failCount++; $display("[TB] FAIL rand_err: got %b want %b", stack_err, mErr); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_call_return();
    test_stack_overflow();
    test_halt();
    test_stall();
    test_reset_in_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
